mips_timer_irq: RTL and testbench

//  Memory-mapped countdown timer on the CPU data bridge; the interrupt source feeding one HWInt line of CP0.

---
 rtl/mips_timer_irq_pkg.sv | 35 +++
 rtl/mips_timer_irq.sv | 141 ++++++++++++++
 tb/tb_mips_timer_irq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_timer_irq_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets, modes, CTRL fields, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_timer_irq_pkg;

   // Word offsets within the 16-byte register window (Addr[3:2])
   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_PRESET = 2'd1;
   localparam logic [1:0] TMR_COUNT  = 2'd2;
   localparam logic [1:0] TMR_RSVD   = 2'd3;

   // CTRL.MODE codes; 1x decodes as one-shot
   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   // CTRL field bit positions
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;

   // Countdown FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tmr_state_t;

   // Only the exact periodic code auto-reloads; every other code is one-shot
   function automatic logic mode_is_periodic(input logic [1:0] mode);
      return (mode == MODE_PERIODIC);
   endfunction

endpackage

// File: rtl/mips_timer_irq.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) raising IRQ to CP0 when the count expires.
// Latency: enable write at edge 0 -> LOAD edge 1 -> CNT(N) edge 2 -> IRQ at edge 2+N; Dout is combinational.
// Backpressure: none; every bus write is accepted in the cycle it is presented.
module mips_timer_irq
   import mips_timer_irq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
   parameter int          CNT_W     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Architectural registers
   logic             ctrl_en;
   logic [1:0]       ctrl_mode;
   logic             ctrl_im;
   logic [CNT_W-1:0] preset;
   logic [CNT_W-1:0] count;
   logic             irq_flag;

   tmr_state_t       state;
   tmr_state_t       state_nxt;

   // Bus decode
   logic       hit;
   logic [1:0] word;
   logic       wr_ctrl;
   logic       wr_preset;
   logic       periodic;
   logic [31:0] preset_ext;
   logic [31:0] count_ext;
   logic        unused_bits;

   assign hit       = (Addr[31:4] == BASE_ADDR[31:4]);
   assign word      = Addr[3:2];
   assign wr_ctrl   = hit && WE && (word == TMR_CTRL);
   assign wr_preset = hit && WE && (word == TMR_PRESET);
   assign periodic  = mode_is_periodic(ctrl_mode);

   // Byte offset bits and upper Din bits carry no information for this block
   assign unused_bits = ^{Addr[1:0], Din};

   // Zero-extend PRESET/COUNT to the 32-bit read bus for any legal CNT_W
   always_comb begin
      preset_ext               = '0;
      count_ext                = '0;
      preset_ext[CNT_W-1:0]    = preset;
      count_ext[CNT_W-1:0]     = count;
   end

   // Read mux: selected register, or 0 on a miss or the reserved word
   always_comb begin
      Dout = '0;
      if (hit) begin
         case (word)
            TMR_CTRL:   Dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            TMR_PRESET: Dout = preset_ext;
            TMR_COUNT:  Dout = count_ext;
            default:    Dout = '0;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // FSM next state; dropping EN in LOAD or CNT returns to IDLE without touching COUNT
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (ctrl_en) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ctrl_en ? ST_CNT : ST_IDLE;
         ST_CNT: begin
            if (!ctrl_en)            state_nxt = ST_IDLE;
            else if (count > CNT_ONE) state_nxt = ST_CNT;
            else                      state_nxt = ST_INT;
         end
         ST_INT:  state_nxt = periodic ? ST_LOAD : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // CTRL register; a bus write beats the one-shot EN auto-clear in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= MODE_ONESHOT;
         ctrl_im   <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en   <= Din[CTRL_EN_BIT];
         ctrl_mode <= Din[CTRL_MODE_MSB:CTRL_MODE_LSB];
         ctrl_im   <= Din[CTRL_IM_BIT];
      end else if ((state == ST_INT) && !periodic) begin
         ctrl_en   <= 1'b0;
      end
   end

   // PRESET register; only sampled into COUNT at LOAD, so mid-count writes wait for the next reload
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          preset <= '0;
      else if (wr_preset) preset <= Din[CNT_W-1:0];
   end

   // COUNT: load from PRESET, then count down and saturate at 0; frozen whenever EN is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (ctrl_en) begin
         if (state == ST_LOAD)      count <= preset;
         else if (state == ST_CNT)  count <= (count > CNT_ONE) ? (count - CNT_ONE) : '0;
      end
   end

   // Interrupt flag: set on entering INT (takes priority), cleared by CTRL writes or on leaving a periodic INT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_flag <= 1'b0;
      end else if ((state_nxt == ST_INT) && (state != ST_INT)) begin
         irq_flag <= 1'b1;
      end else if (wr_ctrl) begin
         irq_flag <= 1'b0;
      end else if ((state == ST_INT) && periodic) begin
         irq_flag <= 1'b0;
      end
   end

   // Both terms are flops with async reset, so IRQ drops as soon as reset asserts
   assign IRQ = irq_flag & ctrl_im;

endmodule

// File: tb/tb_mips_timer_irq.sv
// Directed bench for the timer: bus reads/writes, one-shot, periodic, freeze, mask, reset.
// Latency: checks are placed at exact edge counts relative to the enabling CTRL write.
// Backpressure: none; the bench drives the bus every cycle.
module tb_mips_timer_irq;

   localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
   localparam logic [31:0] A_PRESET = 32'h0000_7F04;
   localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
   localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

   logic        clk;
   logic        reset;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Scoreboard: expectations queued with their tags, popped when the DUT value is sampled
   string       tag_q[$];
   logic [31:0] val_q[$];

   mips_timer_irq #(
      .BASE_ADDR (32'h0000_7F00),
      .CNT_W     (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic exp_push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      val_q.push_back(v);
   endtask

   task automatic obs_check(input logic [31:0] obs);
      string       tag;
      logic [31:0] exp_v;
      n_checks++;
      if (val_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
      end else begin
         tag   = tag_q.pop_front();
         exp_v = val_q.pop_front();
         assert (obs === exp_v) n_pass++;
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
         end
      end
   endtask

   // Advance n rising edges, landing 1 time unit after the last one
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bus write that lands on the next rising edge
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Addr = a;
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
      Din  = '0;
      Addr = '0;
   endtask

   // Combinational read, sampled well before the next edge
   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
      Addr = a;
      exp_push(tag, exp_v);
      #1;
      obs_check(Dout);
   endtask

   task automatic chk_irq(input string tag, input logic exp_v);
      exp_push(tag, {31'd0, exp_v});
      obs_check({31'd0, IRQ});
   endtask

   initial begin
      logic [31:0] ec;
      int          p;

      reset = 1'b1;
      Addr  = '0;
      WE    = 1'b0;
      Din   = '0;
      tick(2);
      reset = 1'b0;
      tick(1);

      // 1: reset state
      rd("rst_ctrl",   A_CTRL,   32'd0);
      rd("rst_preset", A_PRESET, 32'd0);
      rd("rst_count",  A_COUNT,  32'd0);
      rd("rst_rsvd",   A_RSVD,   32'd0);
      chk_irq("rst_irq", 1'b0);

      // 2: one-shot, PRESET=5 -> IRQ at edge 7, held
      wr(A_PRESET, 32'd5);
      wr(A_CTRL, 32'h9);
      for (int e = 1; e <= 6; e++) begin
         tick(1);
         chk_irq($sformatf("t2_irq_low_e%0d", e), 1'b0);
      end
      tick(1);
      chk_irq("t2_irq_rise_e7", 1'b1);
      rd("t2_count_e7", A_COUNT, 32'd0);
      tick(20);
      chk_irq("t2_irq_held", 1'b1);
      rd("t2_ctrl_en_cleared", A_CTRL, 32'h8);
      rd("t2_count_zero", A_COUNT, 32'd0);
      wr(A_CTRL, 32'h8);
      chk_irq("t2_irq_cleared", 1'b0);

      // 3: periodic, PRESET=3 -> pulse every 5 cycles, COUNT 3,2,1,0,0
      wr(A_PRESET, 32'd3);
      wr(A_CTRL, 32'hB);
      for (int e = 1; e <= 12; e++) begin
         tick(1);
         if (e < 2) begin
            ec = 32'd0;
            p  = -1;
         end else begin
            p  = (e - 2) % 5;
            ec = (p < 3) ? 32'(3 - p) : 32'd0;
         end
         rd($sformatf("t3_count_e%0d", e), A_COUNT, ec);
         chk_irq($sformatf("t3_irq_e%0d", e), (p == 3));
      end
      wr(A_CTRL, 32'h8);
      tick(3);

      // 4: freeze mid-count, then re-enable, PRESET write during CNT, CTRL write during INT
      wr(A_PRESET, 32'd10);
      wr(A_CTRL, 32'h9);
      tick(1);
      for (int e = 2; e <= 5; e++) begin
         tick(1);
         rd($sformatf("t4_count_e%0d", e), A_COUNT, 32'(12 - e));
      end
      wr(A_CTRL, 32'h8);
      rd("t4_count_at_disable", A_COUNT, 32'd6);
      tick(3);
      rd("t4_count_frozen", A_COUNT, 32'd6);
      rd("t4_ctrl_disabled", A_CTRL, 32'h8);
      chk_irq("t4_no_irq", 1'b0);
      tick(10);
      rd("t4_count_still_frozen", A_COUNT, 32'd6);
      chk_irq("t4_still_no_irq", 1'b0);
      wr(A_PRESET, 32'd4);
      wr(A_CTRL, 32'h9);
      tick(2);
      rd("t4_reload_preset", A_COUNT, 32'd4);
      wr(A_PRESET, 32'd9);
      rd("t4_preset_wr_no_effect", A_COUNT, 32'd3);
      tick(2);
      rd("t4_count_e5", A_COUNT, 32'd1);
      chk_irq("t4_irq_e5", 1'b0);
      tick(1);
      chk_irq("t4_irq_e6", 1'b1);
      wr(A_CTRL, 32'h9);
      rd("t4_bus_beats_en_clear", A_CTRL, 32'h9);
      chk_irq("t4_irq_cleared_by_wr", 1'b0);
      tick(2);
      rd("t4_new_preset_loaded", A_COUNT, 32'd9);
      wr(A_CTRL, 32'h8);
      rd("t4_preset_value", A_PRESET, 32'd9);

      // 5: masked one-shot; writing CTRL with IM=1 clears the hidden flag
      wr(A_PRESET, 32'd2);
      wr(A_CTRL, 32'h1);
      tick(6);
      chk_irq("t5_masked", 1'b0);
      rd("t5_ctrl", A_CTRL, 32'h0);
      wr(A_CTRL, 32'h8);
      chk_irq("t5_unmask_after_clear", 1'b0);
      tick(2);
      chk_irq("t5_unmask_later", 1'b0);

      // PRESET=0 behaves as N=1: IRQ at edge 3
      wr(A_PRESET, 32'd0);
      wr(A_CTRL, 32'h9);
      tick(2);
      chk_irq("p0_irq_e2", 1'b0);
      tick(1);
      chk_irq("p0_irq_e3", 1'b1);
      rd("p0_count", A_COUNT, 32'd0);

      // 6: async reset while IRQ is high
      reset = 1'b1;
      #1;
      chk_irq("t6_irq_async_drop", 1'b0);
      rd("t6_ctrl",   A_CTRL,   32'd0);
      rd("t6_preset", A_PRESET, 32'd0);
      rd("t6_count",  A_COUNT,  32'd0);
      tick(1);
      reset = 1'b0;
      tick(1);

      // Writes that must not change any register
      wr(A_COUNT, 32'h55);
      rd("t6_count_ro", A_COUNT, 32'd0);
      wr(A_RSVD, 32'hFF);
      rd("t6_rsvd_reads0", A_RSVD, 32'd0);
      wr(32'h0000_7F10, 32'h9);
      rd("t6_ctrl_oow", A_CTRL, 32'd0);
      wr(32'h0000_7E04, 32'd7);
      rd("t6_preset_oow", A_PRESET, 32'd0);
      wr(A_PRESET, 32'd5);
      rd("t6_miss_reads0", 32'h0000_7F14, 32'd0);
      rd("t6_preset_written", A_PRESET, 32'd5);
      rd("t6_ctrl_upper_bits", A_CTRL, 32'd0);
      wr(A_CTRL, 32'hFFFF_FFF0);
      rd("t6_ctrl_upper_discard", A_CTRL, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
